// File: rtl/pla_sweep_pkg.sv
// Shared types and default parameters for the PLA sweep controller.
package pla_sweep_pkg;

    localparam int unsigned X_W_DEF      = 9;
    localparam logic [15:0] SIG_POLY_DEF = 16'h8005;
    localparam logic [15:0] SIG_SEED_DEF = 16'hFFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pla_sweep_misr.sv
// 16-bit serial-input MISR. Load has priority over shift. Reset returns the register to RST_VAL.
module pla_sweep_misr
    import pla_sweep_pkg::*;
#(
    parameter logic [15:0] POLY    = SIG_POLY_DEF,
    parameter logic [15:0] RST_VAL = SIG_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] r_sig;
    logic [15:0] w_next;

    assign w_next = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? POLY : 16'h0000) ^ {15'b0, din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_sig <= RST_VAL;
        else if (load) r_sig <= seed;
        else if (en)   r_sig <= w_next;
    end

    assign sig = r_sig;

endmodule

// File: rtl/pla_sweep_ctrl.sv
// Sweeps an external combinational PLA over [range_lo, range_hi], counting ones and
// compacting the z0 response into a MISR signature.
module pla_sweep_ctrl
    import pla_sweep_pkg::*;
#(
    parameter int unsigned X_W      = X_W_DEF,
    parameter logic [15:0] SIG_POLY = SIG_POLY_DEF,
    parameter logic [15:0] SIG_SEED = SIG_SEED_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           hold,
    input  logic           abort,
    input  logic [X_W-1:0] range_lo,
    input  logic [X_W-1:0] range_hi,
    output logic [X_W-1:0] pla_x,
    input  logic           pla_z,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [X_W:0]   ones_cnt,
    output logic [15:0]    signature
);

    state_t         r_state;
    state_t         w_next_state;
    logic [X_W-1:0] r_x;
    logic [X_W-1:0] r_hi;
    logic [X_W:0]   r_cnt;
    logic           r_done;
    logic           r_err;

    logic w_busy;
    logic w_accept;
    logic w_reject;
    logic w_abort;
    logic w_step;
    logic w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)          w_next_state = ST_RUN;
            ST_RUN:  if (w_abort || w_last) w_next_state = ST_IDLE;
            default:                        w_next_state = ST_IDLE;
        endcase
    end

    // Abort outranks hold and the final vector; hold only gates the step.
    always_comb begin
        w_busy   = 1'b0;
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_abort  = 1'b0;
        w_step   = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = start && (range_lo <= range_hi);
                w_reject = start && (range_lo >  range_hi);
            end
            ST_RUN: begin
                w_busy  = 1'b1;
                w_abort = abort;
                w_step  = !abort && !hold;
                w_last  = !abort && !hold && (r_x == r_hi);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_hi   <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_last;
            r_err  <= w_reject;
            if (w_accept) begin
                r_x   <= range_lo;
                r_hi  <= range_hi;
                r_cnt <= '0;
            end else begin
                if (w_abort || w_last) r_x <= '0;
                else if (w_step)       r_x <= r_x + {{(X_W-1){1'b0}}, 1'b1};
                if (w_step)            r_cnt <= r_cnt + {{X_W{1'b0}}, pla_z};
            end
        end
    end

    pla_sweep_misr #(
        .POLY    (SIG_POLY),
        .RST_VAL (SIG_SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .seed  (SIG_SEED),
        .en    (w_step),
        .din   (pla_z),
        .sig   (signature)
    );

    assign pla_x    = r_x;
    assign busy     = w_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign ones_cnt = r_cnt;

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Scoreboard bench: each completed sweep's expected count/signature is queued by the
// stimulus and compared by a monitor on every done pulse.
module tb_pla_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, hold, abort;
    logic [8:0]  range_lo, range_hi;
    logic [8:0]  pla_x;
    logic        pla_z;
    logic        busy, done, err;
    logic [9:0]  ones_cnt;
    logic [15:0] signature;

    logic [511:0] tbl;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0]  cnt;
        logic [15:0] sig;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // The PLA under test is a truth table the bench reprograms between sweeps.
    assign pla_z = tbl[pla_x];

    pla_sweep_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hold      (hold),
        .abort     (abort),
        .range_lo  (range_lo),
        .range_hi  (range_hi),
        .pla_x     (pla_x),
        .pla_z     (pla_z),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ones_cnt  (ones_cnt),
        .signature (signature)
    );

    function automatic exp_t model(int lo, int hi);
        exp_t e;
        e.cnt = '0;
        e.sig = 16'hFFFF;
        for (int i = lo; i <= hi; i++) begin
            e.cnt = e.cnt + 10'(tbl[i]);
            e.sig = {e.sig[14:0], 1'b0} ^ (e.sig[15] ? 16'h8005 : 16'h0000) ^ {15'b0, tbl[i]};
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_pla_x"}, 32'(pla_x), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_done"},  32'(done), 0);
        chk({tag, "_err"},   32'(err), 0);
        chk({tag, "_cnt"},   32'(ones_cnt), 0);
        chk({tag, "_sig"},   32'(signature), 32'hFFFF);
    endtask

    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no completion pending");
            end else begin
                e = exp_q.pop_front();
                if (ones_cnt !== e.cnt || signature !== e.sig) begin
                    failures++;
                    $display("FAIL sweep_result: got cnt=%0d sig=%h expected cnt=%0d sig=%h",
                             ones_cnt, signature, e.cnt, e.sig);
                end
            end
            if (prev_done) chk("done_one_cycle", 32'(prev_done), 0);
        end
        prev_done = done;
    end

    // Caller sits just after a rising edge. Negative hold_at/abort_at/reset_at disable that event.
    task automatic sweep(int lo, int hi, int hold_at, bit hold_rand, int abort_at, int reset_at);
        int   n_hold = 0, held = 0, busy_cyc = 0;
        bit   fin = 0, did_abort;
        exp_t e;
        if (abort_at < 0 && reset_at < 0) exp_q.push_back(model(lo, hi));
        range_lo = 9'(lo);
        range_hi = 9'(hi);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int g = 0; g < 3000 && !fin; g++) begin
            hold = 1'b0;
            abort = 1'b0;
            did_abort = 1'b0;
            if (reset_at >= 0 && int'(pla_x) == reset_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_vals("midreset");
                rst_n = 1'b1;
                fin = 1;
            end else begin
                if (abort_at >= 0 && int'(pla_x) == abort_at) begin
                    abort = 1'b1;
                    did_abort = 1'b1;
                    hold = 1'(hold_rand);
                end else if ((hold_at >= 0 && int'(pla_x) == hold_at && held < 7) ||
                             (hold_rand && $urandom_range(0, 3) == 0)) begin
                    hold = 1'b1;
                    n_hold++;
                    if (int'(pla_x) == hold_at) held++;
                end
                @(negedge clk);
                if (busy) busy_cyc++;
                @(posedge clk); #1;
                hold = 1'b0;
                abort = 1'b0;
                if (did_abort) begin
                    e = model(lo, abort_at - 1);
                    chk("abort_busy",  32'(busy), 0);
                    chk("abort_pla_x", 32'(pla_x), 0);
                    chk("abort_cnt",   32'(ones_cnt), 32'(e.cnt));
                    chk("abort_sig",   32'(signature), 32'(e.sig));
                    fin = 1;
                end else if (!busy) begin
                    chk("done_at_end", 32'(done), 1);
                    chk("busy_cycles", 32'(busy_cyc), 32'(hi - lo + 1 + n_hold));
                    fin = 1;
                end
            end
        end
        if (!fin) chk("sweep_timeout", 32'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        hold = 1'b0;
        abort = 1'b0;
        range_lo = '0;
        range_hi = '0;
        tbl = '0;
        #12;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 512; i++) tbl[i] = 1'(i);
        sweep(0, 511, -1, 0, -1, -1);
        chk("full_cnt", 32'(ones_cnt), 256);

        for (int i = 0; i < 512; i++) tbl[i] = 1'($urandom_range(0, 1));
        tbl[5] = 1'b1;
        sweep(5, 5, -1, 0, -1, -1);
        chk("single_cnt", 32'(ones_cnt), 1);
        chk("single_sig", 32'(signature), 32'h7FFA);

        range_lo = 9'd10;
        range_hi = 9'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("reject_err",  32'(err), 1);
        chk("reject_busy", 32'(busy), 0);
        chk("reject_cnt",  32'(ones_cnt), 1);
        chk("reject_sig",  32'(signature), 32'h7FFA);
        @(posedge clk); #1;
        chk("reject_err_pulse", 32'(err), 0);

        for (int i = 0; i < 512; i++) tbl[i] = 1'(i);
        sweep(0, 511, 100, 0, -1, -1);
        chk("hold_cnt", 32'(ones_cnt), 256);

        for (int i = 0; i < 512; i++) tbl[i] = 1'($urandom_range(0, 1));
        sweep(0, 511, -1, 0, 200, -1);
        @(posedge clk); #1;
        chk("abort_no_done", 32'(done), 0);

        for (int t = 0; t < 8; t++) begin
            int lo, hi, ab;
            for (int i = 0; i < 512; i++) tbl[i] = 1'($urandom_range(0, 1));
            lo = $urandom_range(0, 511);
            hi = lo + $urandom_range(0, (511 - lo) < 60 ? (511 - lo) : 60);
            ab = (t % 4 == 3 && hi > lo) ? $urandom_range(lo + 1, hi) : -1;
            sweep(lo, hi, -1, 1, ab, -1);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 512; i++) tbl[i] = 1'($urandom_range(0, 1));
        sweep(0, 511, -1, 0, -1, 300);
        sweep(0, 3, -1, 0, -1, -1);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pla_sweep_ctrl.md
PLA_SWEEP_CTRL -- requirements
Module: pla_sweep_ctrl

Interface
REQ-001 Parameter: X_W, default 9, width of the PLA input vector.
REQ-002 Parameter: SIG_POLY, default 16'h8005, MISR feedback polynomial.
REQ-003 Parameter: SIG_SEED, default 16'hFFFF, MISR value loaded at sweep start.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  reset; asynchronous and active-low.
REQ-006 Port: start  input  1  request a sweep; sampled in IDLE only.
REQ-007 Port: hold  input  1  stall the sweep in RUN.
REQ-008 Port: abort  input  1  cancel the sweep in RUN.
REQ-009 Port: range_lo  input  X_W  first vector of the sweep.
REQ-010 Port: range_hi  input  X_W  last vector of the sweep, inclusive.
REQ-011 Port: pla_x  output  X_W  registered drive to the combinational PLA inputs x0..x8 (bit i = xi).
REQ-012 Port: pla_z  input  1  PLA output z0, combinational from pla_x.
REQ-013 Port: busy  output  1  high while in RUN.
REQ-014 Port: done  output  1  one-cycle pulse when a sweep completes.
REQ-015 Port: err  output  1  one-cycle pulse when start is rejected.
REQ-016 Port: ones_cnt  output  X_W+1  count of vectors with pla_z=1.
REQ-017 Port: signature  output  16  MISR of the pla_z sequence.

Function
REQ-018 FSM states: IDLE and RUN only.
REQ-019 IDLE and start=1 and range_lo<=range_hi: at that edge, load pla_x<=range_lo, ones_cnt<=0 and signature<=SIG_SEED, and go to RUN.
REQ-020 IDLE and start=1 and range_lo>range_hi: assert err for one cycle, stay in IDLE, leave results unchanged.
REQ-021 In RUN, start is ignored.
REQ-022 RUN edge with hold=0 and abort=0: sample pla_z for the current pla_x, then ones_cnt += pla_z and signature <= {sig[14:0],1'b0} ^ (sig[15] ? SIG_POLY : 0) ^ {15'b0,pla_z}.
REQ-023 Same edge as REQ-022: if pla_x != range_hi, increment pla_x by 1; otherwise go to IDLE, set pla_x<=0 and assert done for one cycle.
REQ-024 RUN edge with hold=1 and abort=0: pla_x, ones_cnt and signature do not change.
REQ-025 RUN edge with abort=1: go to IDLE and set pla_x<=0. No done pulse and no accumulate. Abort takes priority over hold and over the last vector.
REQ-026 range_lo and range_hi are sampled only at the start edge; the block holds them internally for the whole sweep.
REQ-027 Sweep length is N = hi-lo+1 unheld RUN edges. done is visible in the cycle after the Nth such edge. busy falls on that same edge.
REQ-028 Full sweep 0..511 does not wrap pla_x. ones_cnt maximum is 512, which needs 10 bits.
REQ-029 ones_cnt and signature hold their values in IDLE until the next accepted start.

Reset
REQ-030 rst_n=0 forces asynchronously: state=IDLE, pla_x=0, busy=0, done=0, err=0, ones_cnt=0, signature=SIG_SEED.
REQ-031 Reset asserted mid-sweep discards the sweep with no done pulse. After release the block accepts start on the first edge.

Structure
REQ-032 Package pla_sweep_pkg holds: the state enum, the default SIG_POLY and SIG_SEED, and the X_W default.
REQ-033 The signature register is one sub-module, pla_sweep_misr, with ports: load, seed, en, din, sig.
REQ-034 pla_sweep_ctrl does not instantiate the PLA. The PLA connects externally through pla_x and pla_z.

Verification
REQ-035 Full sweep, lo=0, hi=511, pla_z=pla_x[0]: expect busy for 512 edges, done on the 512th edge, ones_cnt=256, signature equal to the reference-model MISR.
REQ-036 Single vector, lo=hi=5, pla_z=1: expect done on the first edge after start, ones_cnt=1, signature = SIG_SEED step with din=1 = 16'h7FFA.
REQ-037 Rejected range, lo=10, hi=3, start pulse: expect err for 1 cycle, busy=0, ones_cnt and signature unchanged.
REQ-038 Stall, full sweep with hold=1 for 7 cycles at pla_x=100: expect done exactly 7 cycles later than without hold, with identical ones_cnt and signature.
REQ-039 Abort when pla_x=200: expect busy=0 and pla_x=0 at the next edge, no done, ones_cnt equal to the count over vectors 0..199.
REQ-040 Reset mid-sweep at pla_x=300: expect all outputs at reset values immediately. A new start with lo=0, hi=3 must complete normally.
